// File: rtl/park_exit_ctrl_pkg.sv
// Shared definitions for the parking exit controller: exit FSM states,
// gate drive levels and default widths.
package park_exit_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_FEE,
        ST_WAIT_PAY,
        ST_OPEN
    } exit_state_t;

    localparam logic GATE_OPEN  = 1'b1;
    localparam logic GATE_CLOSE = 1'b0;

    localparam int unsigned DEF_N     = 4;
    localparam int unsigned DEF_FEE_W = 8;

endpackage

// File: rtl/park_timebase.sv
// Billing timebase: a prescaler dividing clk by TICK_DIV feeding a
// wrapping FEE_W-bit timestamp counter.
module park_timebase #(
    parameter int unsigned TICK_DIV = 8,
    parameter int unsigned FEE_W    = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    output logic [FEE_W-1:0] o_timestamp
);

    localparam int unsigned PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PS_W-1:0]  r_ps;
    logic [FEE_W-1:0] r_ts;
    logic             w_tc;

    assign w_tc = (r_ps == PS_W'(TICK_DIV - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ps <= '0;
            r_ts <= '0;
        end else begin
            r_ps <= w_tc ? '0 : r_ps + PS_W'(1);
            if (w_tc) begin
                r_ts <= r_ts + FEE_W'(1);
            end
        end
    end

    assign o_timestamp = r_ts;

endmodule

// File: rtl/park_exit_ctrl.sv
// Parking exit controller: slot table fed by the entry gate, sequential
// search on exit request, time-based fee quote and exit gate control.
module park_exit_ctrl
    import park_exit_ctrl_pkg::*;
#(
    parameter int unsigned N        = DEF_N,
    parameter int unsigned SLOTS    = 16,
    parameter int unsigned TICK_DIV = 8,
    parameter int unsigned RATE     = 2,
    parameter int unsigned FEE_W    = DEF_FEE_W,
    parameter int unsigned OPEN_CYC = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   entry_valid,
    input  logic [N-1:0]           entry_vn,
    output logic                   entry_reject,
    input  logic                   exit_req,
    input  logic [N-1:0]           exit_vn,
    output logic [FEE_W-1:0]       fee,
    output logic                   fee_valid,
    input  logic                   pay_valid,
    input  logic [FEE_W-1:0]       pay_amt,
    output logic                   err,
    output logic                   exit_gate,
    output logic [$clog2(SLOTS):0] occupancy,
    output logic                   full
);

    localparam int unsigned IDX_W = $clog2(SLOTS);
    localparam int unsigned OCC_W = IDX_W + 1;
    localparam int unsigned OC_W  = (OPEN_CYC > 1) ? $clog2(OPEN_CYC) : 1;

    logic [FEE_W-1:0]   w_ts;

    logic [N-1:0]       r_slot_vn    [SLOTS];
    logic [FEE_W-1:0]   r_slot_stamp [SLOTS];
    logic [SLOTS-1:0]   r_slot_valid;
    logic [OCC_W-1:0]   r_occ;
    logic               r_reject;

    logic               w_full;
    logic               w_has_free;
    logic               w_dup;
    logic               w_accept;
    logic [IDX_W-1:0]   w_free_idx;

    exit_state_t        r_state;
    exit_state_t        w_state_next;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   r_match_idx;
    logic               r_found;
    logic [N-1:0]       r_exit_vn;
    logic [OC_W-1:0]    r_open_cnt;
    logic [FEE_W-1:0]   r_fee;
    logic               r_fee_valid;
    logic               r_err;
    logic               r_gate;

    logic               w_hit;
    logic               w_err;
    logic               w_release;
    logic [FEE_W-1:0]   w_units;
    logic [2*FEE_W-1:0] w_prod;
    logic [FEE_W-1:0]   w_fee;

    park_timebase #(
        .TICK_DIV (TICK_DIV),
        .FEE_W    (FEE_W)
    ) u_timebase (
        .i_clk       (clk),
        .i_rst       (rst),
        .o_timestamp (w_ts)
    );

    // Lowest free slot and duplicate detection for the incoming vehicle.
    always_comb begin
        w_has_free = 1'b0;
        w_free_idx = '0;
        w_dup      = 1'b0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            if (!r_slot_valid[i] && !w_has_free) begin
                w_has_free = 1'b1;
                w_free_idx = IDX_W'(i);
            end
            if (r_slot_valid[i] && (r_slot_vn[i] == entry_vn)) begin
                w_dup = 1'b1;
            end
        end
    end

    assign w_full   = (r_occ == OCC_W'(SLOTS));
    assign w_accept = entry_valid && !w_full && !w_dup && w_has_free;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_slot_vn[w_free_idx]    <= entry_vn;
            r_slot_stamp[w_free_idx] <= w_ts;
        end
    end

    // A slot released this edge still reads valid, so it cannot be reclaimed until next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot_valid <= '0;
            r_occ        <= '0;
            r_reject     <= 1'b0;
        end else begin
            r_reject <= entry_valid && !w_accept;
            if (w_release) begin
                r_slot_valid[r_match_idx] <= 1'b0;
            end
            if (w_accept) begin
                r_slot_valid[w_free_idx] <= 1'b1;
            end
            case ({w_accept, w_release})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign w_hit = r_slot_valid[r_idx] && (r_slot_vn[r_idx] == r_exit_vn);

    always_comb begin
        w_units = w_ts - r_slot_stamp[r_match_idx];
        if (w_units == '0) begin
            w_units = FEE_W'(1);
        end
        w_prod = (2*FEE_W)'(w_units) * (2*FEE_W)'(RATE);
        w_fee  = (|w_prod[2*FEE_W-1:FEE_W]) ? '1 : w_prod[FEE_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_err        = 1'b0;
        w_release    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (exit_req) begin
                    w_state_next = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                if (r_idx == IDX_W'(SLOTS - 1)) begin
                    if (r_found || w_hit) begin
                        w_state_next = ST_FEE;
                    end else begin
                        w_state_next = ST_IDLE;
                        w_err        = 1'b1;
                    end
                end
            end
            ST_FEE: begin
                w_state_next = ST_WAIT_PAY;
            end
            ST_WAIT_PAY: begin
                if (pay_valid) begin
                    if (pay_amt >= r_fee) begin
                        w_state_next = ST_OPEN;
                        w_release    = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            ST_OPEN: begin
                if (r_open_cnt == OC_W'(OPEN_CYC - 1)) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Status outputs are registered from the current state, so each trails
    // its state by one edge (fee_valid rises SLOTS+2 edges after exit_req).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx       <= '0;
            r_match_idx <= '0;
            r_found     <= 1'b0;
            r_exit_vn   <= '0;
            r_open_cnt  <= '0;
            r_fee       <= '0;
            r_fee_valid <= 1'b0;
            r_err       <= 1'b0;
            r_gate      <= GATE_CLOSE;
        end else begin
            r_err       <= w_err;
            r_fee_valid <= (r_state == ST_WAIT_PAY) && (w_state_next == ST_WAIT_PAY);
            r_gate      <= (r_state == ST_OPEN) ? GATE_OPEN : GATE_CLOSE;
            case (r_state)
                ST_IDLE: begin
                    if (exit_req) begin
                        r_exit_vn <= exit_vn;
                        r_idx     <= '0;
                        r_found   <= 1'b0;
                    end
                end
                ST_SEARCH: begin
                    r_idx <= r_idx + IDX_W'(1);
                    if (w_hit && !r_found) begin
                        r_found     <= 1'b1;
                        r_match_idx <= r_idx;
                    end
                end
                ST_FEE: begin
                    r_fee <= w_fee;
                end
                ST_WAIT_PAY: begin
                    r_open_cnt <= '0;
                end
                ST_OPEN: begin
                    r_open_cnt <= r_open_cnt + OC_W'(1);
                end
                default: begin
                    r_open_cnt <= '0;
                end
            endcase
        end
    end

    assign entry_reject = r_reject;
    assign fee          = r_fee;
    assign fee_valid    = r_fee_valid;
    assign err          = r_err;
    assign exit_gate    = r_gate;
    assign occupancy    = r_occ;
    assign full         = w_full;

endmodule

// File: tb/tb_park_exit_ctrl.sv
// Directed bench for park_exit_ctrl: behavioural slot/timestamp model with a
// fee scoreboard queue, immediate-assertion checks at each observation point.
module tb_park_exit_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       entry_valid;
    logic [3:0] entry_vn;
    logic       entry_reject;
    logic       exit_req;
    logic [3:0] exit_vn;
    logic [7:0] fee;
    logic       fee_valid;
    logic       pay_valid;
    logic [7:0] pay_amt;
    logic       err;
    logic       exit_gate;
    logic [4:0] occupancy;
    logic       full;

    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;
    bit          mdl_in    [16];
    int unsigned mdl_stamp [16];
    int unsigned mdl_occ = 0;
    int          fee_q [$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    park_exit_ctrl #(
        .N(4), .SLOTS(16), .TICK_DIV(8), .RATE(2), .FEE_W(8), .OPEN_CYC(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .entry_valid  (entry_valid),
        .entry_vn     (entry_vn),
        .entry_reject (entry_reject),
        .exit_req     (exit_req),
        .exit_vn      (exit_vn),
        .fee          (fee),
        .fee_valid    (fee_valid),
        .pay_valid    (pay_valid),
        .pay_amt      (pay_amt),
        .err          (err),
        .exit_gate    (exit_gate),
        .occupancy    (occupancy),
        .full         (full)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    function automatic int unsigned ts_at(input int unsigned c);
        return (c / 8) % 256;
    endfunction

    function automatic int exp_fee(input int unsigned now_ts, input int unsigned stamp);
        int unsigned units;
        int unsigned f;
        units = (now_ts - stamp) % 256;
        if (units == 0) units = 1;
        f = units * 2;
        if (f > 255) f = 255;
        return int'(f);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 16; i++) mdl_in[i] = 1'b0;
        mdl_occ = 0;
        fee_q.delete();
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_occ"},  occupancy, 0);
        check({tag, "_full"}, full, 0);
        check({tag, "_gate"}, exit_gate, 0);
        check({tag, "_fv"},   fee_valid, 0);
        check({tag, "_err"},  err, 0);
        check({tag, "_rej"},  entry_reject, 0);
        check({tag, "_fee"},  fee, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1; entry_valid = 1'b0; exit_req = 1'b0; pay_valid = 1'b0;
        entry_vn = '0; exit_vn = '0; pay_amt = '0;
        @(negedge clk);
        rst = 1'b0;
        clear_model();
    endtask

    task automatic wait_cyc(input int unsigned target);
        for (int i = 0; i < 300 && cyc < target; i++) @(negedge clk);
    endtask

    task automatic align8();
        for (int i = 0; i < 8 && (cyc % 8) != 0; i++) @(negedge clk);
    endtask

    task automatic enter(input logic [3:0] vn, input string tag);
        bit exp_rej;
        exp_rej = (mdl_occ == 16) || mdl_in[vn];
        entry_valid = 1'b1; entry_vn = vn;
        if (!exp_rej) begin
            mdl_in[vn] = 1'b1; mdl_stamp[vn] = ts_at(cyc); mdl_occ++;
        end
        @(negedge clk);
        entry_valid = 1'b0;
        check({tag, "_rej"},  entry_reject, 32'(exp_rej));
        check({tag, "_occ"},  occupancy, mdl_occ);
        check({tag, "_full"}, full, 32'(mdl_occ == 16));
    endtask

    task automatic exit_and_quote(input logic [3:0] vn, input string tag);
        int k_fv;
        int errs;
        exit_req = 1'b1; exit_vn = vn;
        fee_q.push_back(exp_fee(ts_at(cyc + 17), mdl_stamp[vn]));
        @(negedge clk);
        exit_req = 1'b0;
        k_fv = -1; errs = 0;
        for (int k = 1; k <= 40 && k_fv < 0; k++) begin
            @(negedge clk);
            if (err) errs++;
            if (fee_valid) k_fv = k;
        end
        check({tag, "_lat"}, k_fv, 18);
        check({tag, "_err"}, errs, 0);
        check({tag, "_sb"},  fee_q.size(), 1);
        if (k_fv >= 0 && fee_q.size() > 0) check({tag, "_fee"}, fee, fee_q.pop_front());
    endtask

    task automatic search_miss(input logic [3:0] vn, input string tag);
        int k_err;
        int errs;
        int fvs;
        exit_req = 1'b1; exit_vn = vn;
        @(negedge clk);
        exit_req = 1'b0;
        k_err = -1; errs = 0; fvs = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (err) begin
                errs++;
                if (k_err < 0) k_err = k;
            end
            if (fee_valid) fvs++;
        end
        check({tag, "_errk"}, k_err, 16);
        check({tag, "_errn"}, errs, 1);
        check({tag, "_fv"},   fvs, 0);
    endtask

    task automatic underpay(input logic [7:0] amt, input string tag);
        pay_valid = 1'b1; pay_amt = amt;
        @(negedge clk);
        pay_valid = 1'b0;
        check({tag, "_err"},  err, 1);
        check({tag, "_gate"}, exit_gate, 0);
        @(negedge clk);
        check({tag, "_err1"}, err, 0);
        check({tag, "_fv"},   fee_valid, 1);
    endtask

    task automatic pay_and_open(input logic [7:0] amt, input logic [3:0] xvn,
                                input bit do_ent, input logic [3:0] evn, input string tag);
        bit exp_rej;
        int highs;
        int first;
        exp_rej = (mdl_occ == 16) || mdl_in[evn];
        pay_valid = 1'b1; pay_amt = amt;
        entry_valid = do_ent; entry_vn = evn;
        mdl_in[xvn] = 1'b0; mdl_occ--;
        if (do_ent && !exp_rej) begin
            mdl_in[evn] = 1'b1; mdl_stamp[evn] = ts_at(cyc); mdl_occ++;
        end
        @(negedge clk);
        pay_valid = 1'b0; entry_valid = 1'b0;
        check({tag, "_occ"},  occupancy, mdl_occ);
        check({tag, "_rej"},  entry_reject, 32'(do_ent && exp_rej));
        check({tag, "_fv0"},  fee_valid, 0);
        check({tag, "_g0"},   exit_gate, 0);
        highs = 0; first = -1;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            if (exit_gate) begin
                highs++;
                if (first < 0) first = j;
            end
        end
        check({tag, "_gate_n"},  highs, 4);
        check({tag, "_gate_at"}, first, 1);
    endtask

    initial begin
        int unsigned c0;

        // 1: reset and idle
        do_reset();
        repeat (20) @(negedge clk);
        check_idle("t1");

        // 2: fee quote 80 cycles after entry, exact payment, gate pulse
        align8();
        c0 = cyc;
        enter(4'd5, "t2_ent");
        wait_cyc(c0 + 63);
        exit_and_quote(4'd5, "t2");
        check("t2_occ1", occupancy, 1);
        pay_and_open(8'd20, 4'd5, 1'b0, 4'd0, "t2_pay");

        // 3: unknown vehicle
        search_miss(4'd9, "t3");

        // 4: fill table, reject when full and on duplicate
        for (int v = 0; v < 16; v++) enter(4'(v), "t4_fill");
        enter(4'd3, "t4_over");
        enter(4'd15, "t4_dupfull");

        // 5: underpayment, overpayment with same-cycle entry
        do_reset();
        check_idle("t5_rst");
        enter(4'd2, "t5_e2");
        align8();
        c0 = cyc;
        enter(4'd7, "t5_e7");
        wait_cyc(c0 + 63);
        exit_and_quote(4'd7, "t5");
        underpay(8'd10, "t5_under");
        pay_and_open(8'd25, 4'd7, 1'b1, 4'd8, "t5_pay");
        enter(4'd8, "t5_dup");
        enter(4'd7, "t5_reuse");

        // 6: reset during SEARCH and during OPEN
        do_reset();
        enter(4'd1, "t6_e1");
        exit_req = 1'b1; exit_vn = 4'd1;
        @(negedge clk);
        exit_req = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        check_idle("t6_search");
        enter(4'd1, "t6_reent");
        exit_and_quote(4'd1, "t6b");
        pay_valid = 1'b1; pay_amt = 8'd255;
        @(negedge clk);
        pay_valid = 1'b0;
        @(negedge clk);
        check("t6_gate_up", exit_gate, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        check_idle("t6_open");
        search_miss(4'd1, "t6_empty");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
